intersection_ctrl: RTL

Two-way intersection sequencer that drives a north–south and an east–west signal head plus a pedestrian walk lamp from one shared millisecond timebase. It walks a fixed phase rotation with an all-red clearance between directions. It inserts a pedestrian walk phase on demand. It sits directly behind the board's 12 MHz clock and button inputs and drives the RGB LEDs.

---
 rtl/intersection_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: two-way intersection sequencer driven from a shared
// millisecond timebase. Rotates NS green/yellow, all-red, EW green/yellow,
// all-red, optionally inserting a pedestrian walk phase after an all-red.
//
// Optional feature macro: INTERSECTION_PED_EN (pedestrian path compiled in).
//
// Ports:
//   CLK       system clock
//   RST       asynchronous active-high reset
//   PED_REQ   pedestrian button (asynchronous level)
//   NS_LED    north-south head (red 3'b011, green 3'b101, yellow 3'b001)
//   EW_LED    east-west head, same encoding
//   PED_WALK  walk lamp, high only in the PED state
//   PED_WAIT  pedestrian request pending
//   STATE     current state code (debug)
module intersection_ctrl #(
  parameter int unsigned CLK_FREQ      = 12000000,
  parameter int unsigned G_PERIOD_MS   = 5000,
  parameter int unsigned Y_PERIOD_MS   = 1000,
  parameter int unsigned AR_PERIOD_MS  = 1000,
  parameter int unsigned PED_PERIOD_MS = 4000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PED_REQ,
  output logic [2:0] NS_LED,
  output logic [2:0] EW_LED,
  output logic       PED_WALK,
  output logic       PED_WAIT,
  output logic [2:0] STATE
);

  localparam int unsigned DIV = CLK_FREQ / 1000;

  localparam logic [2:0] LED_RED = 3'b011;
  localparam logic [2:0] LED_GRN = 3'b101;
  localparam logic [2:0] LED_YEL = 3'b001;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5,
    PED  = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] presc;
  logic [31:0] cnt_ms;
  logic [31:0] period_ms;
  logic        tick;
  logic        adv;

  // Millisecond prescaler; free-running, never cleared by state changes.
  assign tick = (presc == 32'(DIV - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       presc <= 32'd0;
    else if (tick) presc <= 32'd0;
    else           presc <= presc + 32'd1;
  end

  // Duration of the current phase in ms.
  always_comb begin
    period_ms = 32'(G_PERIOD_MS);
    case (state)
      NS_G, EW_G: period_ms = 32'(G_PERIOD_MS);
      NS_Y, EW_Y: period_ms = 32'(Y_PERIOD_MS);
      AR1, AR2:   period_ms = 32'(AR_PERIOD_MS);
      PED:        period_ms = 32'(PED_PERIOD_MS);
      default:    period_ms = 32'(G_PERIOD_MS);
    endcase
  end

  assign adv = tick && (cnt_ms == period_ms - 32'd1);

  // Phase timer: restarts whenever the state changes (including recovery).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    cnt_ms <= 32'd0;
    else if (state_nx != state) cnt_ms <= 32'd0;
    else if (tick)              cnt_ms <= cnt_ms + 32'd1;
  end

`ifdef INTERSECTION_PED_EN
  logic sync1;
  logic sync2;
  logic prev;
  logic rise;
  logic ped_pend;
  logic next_dir;
  logic ped_enter;

  // Button synchronizer and edge detect.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= PED_REQ;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise      = sync2 & ~prev;
  assign ped_enter = (state_nx == PED) && (state != PED);

  // Pending request; a fresh press wins over the clear on PED entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            ped_pend <= 1'b0;
    else if (rise)      ped_pend <= 1'b1;
    else if (ped_enter) ped_pend <= 1'b0;
  end

  // Return direction after PED: 1 = EW_G (came from AR1), 0 = NS_G.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            next_dir <= 1'b0;
    else if (ped_enter) next_dir <= (state == AR1);
  end

  assign PED_WALK = (state == PED);
  assign PED_WAIT = ped_pend;
`else
  logic unused_ped_req;
  assign unused_ped_req = PED_REQ;

  assign PED_WALK = 1'b0;
  assign PED_WAIT = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= NS_G;
    else     state <= state_nx;
  end

  // Next-state logic; unknown codes recover to NS_G immediately.
  always_comb begin
    state_nx = state;
    case (state)
      NS_G: if (adv) state_nx = NS_Y;
      NS_Y: if (adv) state_nx = AR1;
`ifdef INTERSECTION_PED_EN
      AR1:  if (adv) state_nx = ped_pend ? PED : EW_G;
`else
      AR1:  if (adv) state_nx = EW_G;
`endif
      EW_G: if (adv) state_nx = EW_Y;
      EW_Y: if (adv) state_nx = AR2;
`ifdef INTERSECTION_PED_EN
      AR2:  if (adv) state_nx = ped_pend ? PED : NS_G;
      PED:  if (adv) state_nx = next_dir ? EW_G : NS_G;
`else
      AR2:  if (adv) state_nx = NS_G;
`endif
      default: state_nx = NS_G;
    endcase
  end

  // Signal head decode from the state register.
  always_comb begin
    NS_LED = 3'b000;
    EW_LED = 3'b000;
    case (state)
      NS_G: begin NS_LED = LED_GRN; EW_LED = LED_RED; end
      NS_Y: begin NS_LED = LED_YEL; EW_LED = LED_RED; end
      EW_G: begin NS_LED = LED_RED; EW_LED = LED_GRN; end
      EW_Y: begin NS_LED = LED_RED; EW_LED = LED_YEL; end
      AR1, AR2: begin NS_LED = LED_RED; EW_LED = LED_RED; end
`ifdef INTERSECTION_PED_EN
      PED:  begin NS_LED = LED_RED; EW_LED = LED_RED; end
`endif
      default: begin NS_LED = 3'b000; EW_LED = 3'b000; end
    endcase
  end

  assign STATE = 3'(state);

endmodule
